// File: rtl/seven_seg_scan_driver.sv
// Multiplexed 8-digit 7-segment driver: frame-latched shadow patterns, dead-time
// between digits, registered active-low anode/cathode outputs.
module seven_seg_scan_driver #(
  parameter int CLK_DIV = 100000,
  parameter int DEAD    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [6:0] Hex_Digit0,
  input  logic [6:0] Hex_Digit1,
  input  logic [6:0] Hex_Digit2,
  input  logic [6:0] Hex_Digit3,
  input  logic [6:0] Hex_Digit4,
  input  logic [6:0] Hex_Digit5,
  input  logic [6:0] Hex_Digit6,
  input  logic [6:0] Hex_Digit7,
  input  logic [7:0] dp_mask,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  // SCAN doubles as the "frame loaded" flag: it is only reached through a load cycle.
  typedef enum logic {PARK, SCAN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0][6:0]  shadow_q, shadow_d, hex_in;
  logic [7:0]       sdp_q, sdp_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d, tick_q, tick_d;
  logic             slot_end, frame_end, in_dead;

  assign hex_in = {Hex_Digit7, Hex_Digit6, Hex_Digit5, Hex_Digit4,
                   Hex_Digit3, Hex_Digit2, Hex_Digit1, Hex_Digit0};

  assign slot_end  = (cnt_q == CNT_MAX);
  assign frame_end = slot_end && (idx_q == 3'd7);

  generate
    if (DEAD == 0) begin : g_no_dead
      assign in_dead = 1'b0;
    end else begin : g_dead
      assign in_dead = (cnt_q < CNT_W'(DEAD));
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    sdp_d    = sdp_q;
    an_d     = 8'hFF;
    seg_d    = 7'h7F;
    dp_d     = 1'b1;
    tick_d   = 1'b0;
    if (!en) begin
      state_d = PARK;
      cnt_d   = '0;
      idx_d   = 3'd0;
    end else if (state_q == PARK) begin
      state_d  = SCAN;
      shadow_d = hex_in;
      sdp_d    = dp_mask;
      cnt_d    = '0;
      idx_d    = 3'd0;
    end else begin
      if (slot_end) begin
        cnt_d = '0;
        idx_d = idx_q + 3'd1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      // Frame boundary: latch the next frame so mid-frame input changes never tear.
      if (frame_end) begin
        shadow_d = hex_in;
        sdp_d    = dp_mask;
        tick_d   = 1'b1;
      end
      if (!in_dead) begin
        an_d  = ~(8'd1 << idx_q);
        seg_d = shadow_q[idx_q];
        dp_d  = ~sdp_q[idx_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= PARK;
      cnt_q    <= '0;
      idx_q    <= 3'd0;
      shadow_q <= {8{7'h7F}};
      sdp_q    <= 8'h00;
      an_q     <= 8'hFF;
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      sdp_q    <= sdp_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      tick_q   <= tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = tick_q;

endmodule
